target_machine_decoder: RTL and testbench

- Receive-side counterpart of the machine-select byte sender: consumes bytes from the UART receiver and recovers the selected target machine.
- Classifies each byte, confirms select frames by repetition within a gap window, then commits a stable machine_id for downstream display and game logic.
- Also reports deselect, framing errors and a saturating error count.

---
 rtl/target_proto_pkg.sv | 22 ++
 rtl/target_frame_classify.sv | 28 ++
 rtl/target_machine_decoder.sv | 131 +++++++++++++
 tb/tb_target_machine_decoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/target_proto_pkg.sv
// Shared protocol definitions for the machine-select byte link.
// Used by both the sender and the receive-side decoder.
package target_proto_pkg;

  localparam logic [1:0] TYPE_SELECT    = 2'b11;
  localparam logic [7:0] DESELECT_BYTE  = 8'h03;
  localparam int         MAX_ID_DEFAULT = 20;
  localparam int         ID_W           = 5;

  typedef enum logic [1:0] {
    NOT_OURS,
    DESELECT,
    CANDIDATE,
    ERROR
  } frame_class_e;

  typedef enum logic {
    S_IDLE,
    S_CONFIRM
  } state_e;

endpackage

// File: rtl/target_frame_classify.sv
// Combinational byte classifier: splits a received byte into frame class and payload.
// Shared between the decoder and the sender's self-check bench.
module target_frame_classify
  import target_proto_pkg::*;
#(
  parameter int MAX_ID = MAX_ID_DEFAULT
) (
  input  logic [7:0]      rx_data,
  output frame_class_e    frame_class,
  output logic [ID_W-1:0] payload
);

  localparam logic [ID_W:0] MAX_ID_L = (ID_W + 1)'(MAX_ID);

  always_comb begin
    payload     = rx_data[6:2];
    frame_class = CANDIDATE;
    if (rx_data[1:0] != TYPE_SELECT) begin
      frame_class = NOT_OURS;
    end else if (rx_data == DESELECT_BYTE) begin
      frame_class = DESELECT;
    end else if (rx_data[7] || ({1'b0, rx_data[6:2]} > MAX_ID_L)) begin
      // Payload 0 with bit7 set also lands here, not in DESELECT.
      frame_class = ERROR;
    end
  end

endmodule

// File: rtl/target_machine_decoder.sv
// Receive-side machine-select decoder: confirms repeated select frames within a
// gap window and commits a stable machine_id; reports deselects and bad frames.
module target_machine_decoder
  import target_proto_pkg::*;
#(
  parameter int MAX_ID      = MAX_ID_DEFAULT,
  parameter int CONFIRM_CNT = 2,
  parameter int GAP_CYCLES  = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [ID_W-1:0] machine_id,
  output logic            machine_valid,
  output logic            select_changed,
  output logic            ignore_seen,
  output logic            frame_error,
  output logic [7:0]      error_count
);

  localparam int               GAP_W       = $clog2(GAP_CYCLES + 1);
  localparam logic [3:0]       CONFIRM_TGT = 4'(CONFIRM_CNT);
  localparam logic [GAP_W-1:0] GAP_LIMIT   = GAP_W'(GAP_CYCLES);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage 0: classify the incoming byte and derive confirmation decisions
  frame_class_e    cls_p0;
  logic [ID_W-1:0] payload_p0;
  logic            vld_p0;

  state_e          state_p1;
  logic [ID_W-1:0] cand_p1;
  logic [3:0]      match_cnt_p1;
  logic [GAP_W-1:0] gap_cnt_p1;

  logic             same_cand_p0;
  logic [3:0]       cnt_next_p0;
  logic             confirm_done_p0;
  logic             is_new_id_p0;
  logic [GAP_W-1:0] gap_next;

  target_frame_classify #(
    .MAX_ID(MAX_ID)
  ) u_classify (
    .rx_data    (rx_data),
    .frame_class(cls_p0),
    .payload    (payload_p0)
  );

  assign vld_p0          = rx_valid;
  assign same_cand_p0    = (state_p1 == S_CONFIRM) && (payload_p0 == cand_p1);
  // A fresh candidate counts as its own first match, so CONFIRM_CNT=1 commits at once.
  assign cnt_next_p0     = same_cand_p0 ? (match_cnt_p1 + 4'd1) : 4'd1;
  assign confirm_done_p0 = (cnt_next_p0 == CONFIRM_TGT);
  assign is_new_id_p0    = !machine_valid || (machine_id != payload_p0);
  assign gap_next        = gap_cnt_p1 + GAP_W'(1);

  // Stage 1: registered FSM state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1       <= S_IDLE;
      cand_p1        <= '0;
      match_cnt_p1   <= '0;
      gap_cnt_p1     <= '0;
      machine_id     <= '0;
      machine_valid  <= 1'b0;
      select_changed <= 1'b0;
      ignore_seen    <= 1'b0;
      frame_error    <= 1'b0;
      error_count    <= '0;
    end else begin
      select_changed <= 1'b0;
      ignore_seen    <= 1'b0;
      frame_error    <= 1'b0;
      if (vld_p0) begin
        case (cls_p0)
          DESELECT: begin
            select_changed <= machine_valid;
            ignore_seen    <= 1'b1;
            machine_id     <= '0;
            machine_valid  <= 1'b0;
            state_p1       <= S_IDLE;
            cand_p1        <= '0;
            match_cnt_p1   <= '0;
            gap_cnt_p1     <= '0;
          end
          ERROR: begin
            frame_error  <= 1'b1;
            error_count  <= sat_inc(error_count);
            state_p1     <= S_IDLE;
            cand_p1      <= '0;
            match_cnt_p1 <= '0;
            gap_cnt_p1   <= '0;
          end
          CANDIDATE: begin
            if (confirm_done_p0) begin
              select_changed <= is_new_id_p0;
              machine_id     <= payload_p0;
              machine_valid  <= 1'b1;
              state_p1       <= S_IDLE;
              cand_p1        <= '0;
              match_cnt_p1   <= '0;
              gap_cnt_p1     <= '0;
            end else begin
              state_p1     <= S_CONFIRM;
              cand_p1      <= payload_p0;
              match_cnt_p1 <= cnt_next_p0;
              gap_cnt_p1   <= '0;
            end
          end
          default: begin
          end
        endcase
      end else if (state_p1 == S_CONFIRM) begin
        if (gap_next == GAP_LIMIT) begin
          state_p1     <= S_IDLE;
          cand_p1      <= '0;
          match_cnt_p1 <= '0;
          gap_cnt_p1   <= '0;
        end else begin
          gap_cnt_p1 <= gap_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_target_machine_decoder.sv
// Bench for target_machine_decoder: directed vector table, async-reset corners and
// random traffic against a behavioural model, on CONFIRM_CNT=2 and =1 instances.
module tb_target_machine_decoder;

  localparam int MAXID = 20;
  localparam int GAP   = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;

  logic [4:0] id_a, id_b;
  logic       mv_a, mv_b, sc_a, sc_b, ig_a, ig_b, fe_a, fe_b;
  logic [7:0] ec_a, ec_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  target_machine_decoder #(.MAX_ID(MAXID), .CONFIRM_CNT(2), .GAP_CYCLES(GAP)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .machine_id(id_a), .machine_valid(mv_a), .select_changed(sc_a),
    .ignore_seen(ig_a), .frame_error(fe_a), .error_count(ec_a)
  );

  target_machine_decoder #(.MAX_ID(MAXID), .CONFIRM_CNT(1), .GAP_CYCLES(GAP)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .machine_id(id_b), .machine_valid(mv_b), .select_changed(sc_b),
    .ignore_seen(ig_b), .frame_error(fe_b), .error_count(ec_b)
  );

  typedef struct {
    int idle;
    int b;
    int id;
    int vld;
    int sc;
    int ig;
    int fe;
    int errs;
  } vec_t;

  typedef struct {
    int id;
    int valid;
    int cand;
    int count;
    int idle;
    int errs;
    int sc;
    int ig;
    int fe;
  } model_t;

  vec_t tbl[$];

  task automatic add(input int idle, input int b, input int id, input int vld,
                     input int sc, input int ig, input int fe, input int errs);
    vec_t e;
    e.idle = idle; e.b = b; e.id = id; e.vld = vld;
    e.sc = sc; e.ig = ig; e.fe = fe; e.errs = errs;
    tbl.push_back(e);
  endtask

  // Model: a pending candidate is "count > 0"; commit once count reaches the need.
  function automatic void mstep(inout model_t m, input int v, input int b, input int need);
    int p;
    p = (b / 4) % 32;
    m.sc = 0; m.ig = 0; m.fe = 0;
    if (v != 0) begin
      if (b % 4 == 3) begin
        if (b == 3) begin
          m.sc = m.valid; m.ig = 1; m.id = 0; m.valid = 0; m.count = 0;
        end else if (b >= 128 || p > MAXID) begin
          m.fe = 1;
          if (m.errs < 255) m.errs++;
          m.count = 0;
        end else begin
          if (m.count > 0 && p == m.cand) m.count++;
          else begin m.cand = p; m.count = 1; end
          m.idle = 0;
          if (m.count >= need) begin
            m.sc = (m.valid == 0 || m.id != p) ? 1 : 0;
            m.id = p; m.valid = 1; m.count = 0;
          end
        end
      end
    end else if (m.count > 0) begin
      m.idle++;
      if (m.idle >= GAP) m.count = 0;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int id, input int v, input int sc,
                       input int ig, input int fe, input int ec);
    chk({tag, ".a.id"}, int'(id_a), id);
    chk({tag, ".a.valid"}, int'(mv_a), v);
    chk({tag, ".a.sel_chg"}, int'(sc_a), sc);
    chk({tag, ".a.ignore"}, int'(ig_a), ig);
    chk({tag, ".a.ferr"}, int'(fe_a), fe);
    chk({tag, ".a.errcnt"}, int'(ec_a), ec);
  endtask

  task automatic chk_b(input string tag, input int id, input int v, input int sc,
                       input int ig, input int fe, input int ec);
    chk({tag, ".b.id"}, int'(id_b), id);
    chk({tag, ".b.valid"}, int'(mv_b), v);
    chk({tag, ".b.sel_chg"}, int'(sc_b), sc);
    chk({tag, ".b.ignore"}, int'(ig_b), ig);
    chk({tag, ".b.ferr"}, int'(fe_b), fe);
    chk({tag, ".b.errcnt"}, int'(ec_b), ec);
  endtask

  // Called at a falling edge; returns at the next one with the byte's effect visible.
  task automatic send(input int b);
    rx_data  = 8'(b);
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int pick_byte();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 4) return int'($urandom_range(1, 3)) * 4 + 3;
    if (r == 5) return 3;
    if (r == 6) begin
      if ($urandom_range(0, 1) == 0) return 128 + int'($urandom_range(0, 31)) * 4 + 3;
      return int'($urandom_range(21, 31)) * 4 + 3;
    end
    if (r == 7) return int'($urandom_range(0, 63)) * 4 + int'($urandom_range(0, 2));
    if (r == 8) return 20 * 4 + 3;
    return int'($urandom_range(1, 2)) * 4 + 3;
  endfunction

  initial begin
    model_t ma, mb;
    int burst;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // idle, byte, id, valid, select_changed, ignore_seen, frame_error, error_count
    add(0,   8'h0F, 0, 0, 0, 0, 0, 0);
    add(10,  8'h0F, 3, 1, 1, 0, 0, 0);
    add(0,   8'h0F, 3, 1, 0, 0, 0, 0);
    add(0,   8'h0F, 3, 1, 0, 0, 0, 0);
    add(0,   8'h0F, 3, 1, 0, 0, 0, 0);
    add(0,   8'h13, 3, 1, 0, 0, 0, 0);
    add(0,   8'h13, 4, 1, 1, 0, 0, 0);
    add(0,   8'h0F, 4, 1, 0, 0, 0, 0);
    add(100, 8'h0F, 4, 1, 0, 0, 0, 0);
    add(99,  8'h0F, 3, 1, 1, 0, 0, 0);
    add(0,   8'h03, 0, 0, 1, 1, 0, 0);
    add(0,   8'h01, 0, 0, 0, 0, 0, 0);
    add(0,   8'h02, 0, 0, 0, 0, 0, 0);
    add(0,   8'h03, 0, 0, 0, 1, 0, 0);
    add(0,   8'h0F, 0, 0, 0, 0, 0, 0);
    add(0,   8'h0F, 3, 1, 1, 0, 0, 0);
    add(0,   8'h57, 3, 1, 0, 0, 1, 1);
    add(0,   8'h8F, 3, 1, 0, 0, 1, 2);
    add(0,   8'h13, 3, 1, 0, 0, 0, 2);
    add(0,   8'h57, 3, 1, 0, 0, 1, 3);
    add(0,   8'h13, 3, 1, 0, 0, 0, 3);
    add(0,   8'h13, 4, 1, 1, 0, 0, 3);
    add(0,   8'h0F, 4, 1, 0, 0, 0, 3);
    add(0,   8'h01, 4, 1, 0, 0, 0, 3);
    add(0,   8'h0F, 3, 1, 1, 0, 0, 3);
    add(0,   8'h13, 3, 1, 0, 0, 0, 3);
    add(0,   8'h03, 0, 0, 1, 1, 0, 3);
    add(0,   8'h13, 0, 0, 0, 0, 0, 3);
    add(0,   8'h13, 4, 1, 1, 0, 0, 3);
    add(0,   8'h83, 4, 1, 0, 0, 1, 4);
    add(0,   8'h53, 4, 1, 0, 0, 0, 4);
    add(0,   8'h53, 20, 1, 1, 0, 0, 4);

    idle(2);
    chk_a("reset", 0, 0, 0, 0, 0, 0);
    chk_b("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(1);

    foreach (tbl[i]) begin
      idle(tbl[i].idle);
      send(tbl[i].b);
      chk_a($sformatf("vec%0d", i), tbl[i].id, tbl[i].vld, tbl[i].sc,
            tbl[i].ig, tbl[i].fe, tbl[i].errs);
    end
    idle(1);
    chk_a("pulse_len", 20, 1, 0, 0, 0, 4);

    repeat (300) send(8'h8F);
    chk_a("sat", 20, 1, 0, 0, 1, 255);
    idle(1);
    chk_a("sat_hold", 20, 1, 0, 0, 0, 255);

    send(8'h17);
    send(8'h17);
    chk_a("id5", 5, 1, 1, 0, 0, 255);
    send(8'h17);
    chk_a("id5_confirm", 5, 1, 0, 0, 0, 255);
    #2 rst_n = 1'b0;
    #1;
    chk_a("async_rst", 0, 0, 0, 0, 0, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk_a("post_rst", 0, 0, 0, 0, 0, 0);

    send(8'h0F);
    chk_b("b_commit", 3, 1, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_b("b_pulse_lost", 0, 0, 0, 0, 0, 0);
    idle(2);
    rst_n = 1'b1;

    ma = '{default: 0};
    mb = '{default: 0};
    burst = 0;
    for (int c = 0; c < 5000; c++) begin
      int v;
      int b;
      if (burst > 0) begin
        v = 0;
        burst--;
      end else if ($urandom_range(0, 299) == 0) begin
        burst = int'($urandom_range(95, 105));
        v = 0;
      end else begin
        v = ($urandom_range(0, 9) < 4) ? 1 : 0;
      end
      b = pick_byte();
      rx_valid = (v != 0);
      rx_data  = 8'(b);
      mstep(ma, v, b, 2);
      mstep(mb, v, b, 1);
      @(negedge clk);
      chk_a("rnd", ma.id, ma.valid, ma.sc, ma.ig, ma.fe, ma.errs);
      chk_b("rnd", mb.id, mb.valid, mb.sc, mb.ig, mb.fe, mb.errs);
    end
    rx_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
